// File: rtl/writeback_unit_if.sv
// Handshake and register-bank bundle for the writeback unit: two result
// producers (load path, ALU path) in, one register-bank write port out.
interface writeback_unit_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          mem_valid;
    logic [4:0]    mem_dest;
    logic [31:0]   mem_data;
    logic          mem_ready;
    logic          alu_valid;
    logic [4:0]    alu_dest;
    logic [31:0]   alu_data;
    logic          alu_ready;
    logic [4:0]    WriteRegister;
    logic [31:0]   WriteData;
    logic          RegWrite;
    logic [31:0]   busy_mask;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport slave (
        input  mem_valid, mem_dest, mem_data,
        input  alu_valid, alu_dest, alu_data,
        output mem_ready, alu_ready,
        output WriteRegister, WriteData, RegWrite,
        output busy_mask, count, full, empty
    );

    modport master (
        output mem_valid, mem_dest, mem_data,
        output alu_valid, alu_dest, alu_data,
        input  mem_ready, alu_ready,
        input  WriteRegister, WriteData, RegWrite,
        input  busy_mask, count, full, empty
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: merges load and ALU results into a small FIFO and drains it
// to the register bank with a two-cycle setup/strobe write protocol.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    writeback_unit_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    state_t        state_q;
    logic [4:0]    dest_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [4:0]    wreg_q;
    logic [31:0]   wdata_q;
    logic          regwrite_q;

    logic          full;
    logic          empty;
    logic          accept_mem;
    logic          accept_alu;
    logic [4:0]    in_dest;
    logic [31:0]   in_data;
    logic          push;
    logic          pop;
    logic [31:0]   busy_mask;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Load path wins when both producers offer in the same cycle.
    assign accept_mem = bus.mem_valid && !full;
    assign accept_alu = bus.alu_valid && !full && !bus.mem_valid;
    assign in_dest    = accept_mem ? bus.mem_dest : bus.alu_dest;
    assign in_data    = accept_mem ? bus.mem_data : bus.alu_data;

    // Writes to r0 are acknowledged but dropped here.
    assign push = (accept_mem || accept_alu) && (in_dest != 5'd0);
    assign pop  = !empty && ((state_q == IDLE) || (state_q == STROBE));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr_q] <= in_dest;
            data_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wreg_q     <= '0;
            wdata_q    <= '0;
            regwrite_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    regwrite_q <= 1'b0;
                    if (pop) begin
                        wreg_q  <= dest_q[rd_ptr_q];
                        wdata_q <= data_q[rd_ptr_q];
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    regwrite_q <= 1'b1;
                    state_q    <= STROBE;
                end
                STROBE: begin
                    regwrite_q <= 1'b0;
                    if (pop) begin
                        wreg_q  <= dest_q[rd_ptr_q];
                        wdata_q <= data_q[rd_ptr_q];
                        state_q <= SETUP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    regwrite_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, AW'(AW'(i) - rd_ptr_q)} < count_q) begin
                busy_mask[dest_q[i]] = 1'b1;
            end
        end
        if (state_q != IDLE) begin
            busy_mask[wreg_q] = 1'b1;
        end
    end

    assign bus.mem_ready     = !full;
    assign bus.alu_ready     = !full && !bus.mem_valid;
    assign bus.WriteRegister = wreg_q;
    assign bus.WriteData     = wdata_q;
    assign bus.RegWrite      = regwrite_q;
    assign bus.busy_mask     = busy_mask;
    assign bus.count         = count_q;
    assign bus.full          = full;
    assign bus.empty         = empty;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: offers are scoreboarded on acceptance and
// popped when the register bank strobe is observed.
module tb_writeback_unit;
    logic clk;
    logic reset;

    writeback_unit_if #(.DEPTH(4)) bus ();

    writeback_unit #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    bit          saw_full = 0;
    bit          prev_rw = 0;
    logic [31:0] last7 = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bank-side monitor: ready relations every cycle, strobe contents vs scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_rw = 1'b0;
        end else begin
            chk("mem_ready_rel", bus.mem_ready, !bus.full);
            chk("alu_ready_rel", bus.alu_ready, !bus.full && !bus.mem_valid);
            if (bus.full) saw_full = 1'b1;
            if (bus.RegWrite) begin
                ent_t e;
                strobe_cnt++;
                chk("strobe_gap", prev_rw, 1'b0);
                chk("strobe_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_reg", bus.WriteRegister, e.d);
                    chk("wr_data", bus.WriteData, e.v);
                end
                if (bus.WriteRegister == 5'd7) last7 = bus.WriteData;
            end
            prev_rw = bus.RegWrite;
        end
    end

    task automatic offer(input bit is_mem, input logic [4:0] d, input logic [31:0] v);
        bit ok = 1'b0;
        if (is_mem) begin
            bus.mem_valid = 1'b1; bus.mem_dest = d; bus.mem_data = v;
        end else begin
            bus.alu_valid = 1'b1; bus.alu_dest = d; bus.alu_data = v;
        end
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (is_mem ? bus.mem_ready : bus.alu_ready) begin
                ok = 1'b1;
                if (d != 5'd0) sb.push_back('{d, v});
            end
            @(posedge clk);
            #1;
        end
        if (is_mem) bus.mem_valid = 1'b0;
        else        bus.alu_valid = 1'b0;
        chk("offer_accepted", ok, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.RegWrite == 1'b0 && bus.count == '0 && bus.busy_mask == '0)
                done = 1'b1;
        end
        chk(tag, done, 1'b1);
        chk({tag, "_empty"}, bus.empty, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        bit done;
        reset = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
        bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;

        // Reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_regwrite", bus.RegWrite, 0);
        chk("rst_wreg", bus.WriteRegister, 0);
        chk("rst_wdata", bus.WriteData, 0);
        chk("rst_busy", bus.busy_mask, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_ready", bus.mem_ready, 1);
        chk("post_rst_alu_ready", bus.alu_ready, 1);
        @(posedge clk); #1;

        // Single ALU write, exact latency.
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd5; bus.alu_data = 32'h0000_002A;
        @(negedge clk);
        chk("s1_ready", bus.alu_ready, 1);
        sb.push_back('{5'd5, 32'h0000_002A});
        @(posedge clk); #1 bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("s1_k_count", bus.count, 1);
        chk("s1_k_busy", bus.busy_mask, 32'h20);
        chk("s1_k_rw", bus.RegWrite, 0);
        @(negedge clk);
        chk("s1_setup_rw", bus.RegWrite, 0);
        chk("s1_setup_wreg", bus.WriteRegister, 5);
        chk("s1_setup_wdata", bus.WriteData, 32'h2A);
        chk("s1_setup_busy", bus.busy_mask, 32'h20);
        chk("s1_setup_count", bus.count, 0);
        @(negedge clk);
        chk("s1_strobe_rw", bus.RegWrite, 1);
        chk("s1_strobe_busy", bus.busy_mask, 32'h20);
        @(negedge clk);
        chk("s1_after_rw", bus.RegWrite, 0);
        chk("s1_after_busy", bus.busy_mask, 0);
        @(posedge clk); #1;

        // Write to r0 completes the handshake and is dropped.
        base = strobe_cnt;
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("r0_ready", bus.alu_ready, 1);
        @(posedge clk); #1 bus.alu_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("r0_busy", bus.busy_mask, 0);
            chk("r0_count", bus.count, 0);
        end
        chk("r0_no_strobe", strobe_cnt, base);
        @(posedge clk); #1;

        // Both producers at once: load path first.
        base = strobe_cnt;
        bus.mem_valid = 1'b1; bus.mem_dest = 5'd3; bus.mem_data = 32'h11;
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd4; bus.alu_data = 32'h22;
        @(negedge clk);
        chk("prio_mem_ready", bus.mem_ready, 1);
        chk("prio_alu_ready", bus.alu_ready, 0);
        sb.push_back('{5'd3, 32'h11});
        @(posedge clk); #1 bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("prio_alu_ready2", bus.alu_ready, 1);
        sb.push_back('{5'd4, 32'h22});
        @(posedge clk); #1 bus.alu_valid = 1'b0;
        wait_idle("prio_drain");
        chk("prio_strobes", strobe_cnt - base, 2);

        // Back-to-back burst r1..r5.
        for (int d = 1; d <= 5; d++) offer(1'b0, 5'(d), 32'(100 + d));
        wait_idle("burst5_drain");
        chk("burst5_count", bus.count, 0);

        // Longer burst fills the queue, exercises backpressure and pointer wrap.
        saw_full = 1'b0;
        for (int d = 1; d <= 12; d++) offer(1'b0, 5'(d + 16), 32'(d) * 32'h0101_0101);
        wait_idle("burst12_drain");
        chk("burst12_saw_full", saw_full, 1);

        // Two writes to r7: busy bit held until the second strobe ends.
        base = strobe_cnt;
        offer(1'b0, 5'd7, 32'hA);
        offer(1'b0, 5'd7, 32'hB);
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk); #1;
            if (strobe_cnt == base + 2 && !bus.RegWrite) done = 1'b1;
            else chk("r7_busy_hold", bus.busy_mask[7], 1);
        end
        chk("r7_done", done, 1);
        chk("r7_busy_clear", bus.busy_mask[7], 0);
        chk("r7_final", last7, 32'hB);
        @(posedge clk); #1;

        // Reset during a strobe with two entries pending.
        offer(1'b0, 5'd9,  32'h99);
        offer(1'b0, 5'd10, 32'hAA);
        offer(1'b0, 5'd11, 32'hBB);
        @(negedge clk);
        chk("rst2_rw_before", bus.RegWrite, 1);
        chk("rst2_count_before", bus.count, 2);
        #1 reset = 1'b1;
        #1;
        chk("rst2_rw", bus.RegWrite, 0);
        chk("rst2_count", bus.count, 0);
        chk("rst2_empty", bus.empty, 1);
        chk("rst2_busy", bus.busy_mask, 0);
        chk("rst2_wreg", bus.WriteRegister, 0);
        sb.delete();
        base = strobe_cnt;
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        for (int n = 0; n < 10; n++) @(negedge clk);
        chk("rst2_no_strobe", strobe_cnt, base);
        chk("rst2_count_after", bus.count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
